// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Result and carry-out are registered and held until the next completion.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_shift;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Next-state logic: one operand bit pair is consumed per RUN cycle.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // Written this way so WIDTH=1 needs no special-cased slice.
    res_shift            = res_q >> 1'b1;
    res_shift[WIDTH-1]   = fa_s;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1'b1;
        opb_d   = opb_q >> 1'b1;
        res_d   = res_shift;
        carry_d = fa_c;
        busy_d  = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = res_shift;
          cout_d  = fa_c;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 1-bit instance checked
// against plain integer addition of the captured operands.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one 8-bit op and wait (bounded) for done; cyc = edges after accept.
  task automatic run8(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                      output int cyc, output logic [7:0] s, output logic co);
    a8 = aa; b8 = bb; cin8 = cc; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 12) begin
      step();
      cyc++;
    end
    s = sum8; co = cout8;
  endtask

  task automatic run1(input logic aa, input logic bb, input logic cc,
                      output int cyc, output logic [1:0] r);
    a1 = aa; b1 = bb; cin1 = cc; start1 = 1'b1;
    step();
    start1 = 1'b0;
    a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 6) begin
      step();
      cyc++;
    end
    r = {cout1, sum1};
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; start1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_hold8: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
      end
      n_cmp++;
      if ({busy1, done1, sum1, cout1} !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold1: got busy=%b done=%b sum=%b cout=%b, want all 0", busy1, done1, sum1, cout1);
      end
    end
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    step();
    n_cmp++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
    end
  endtask

  task automatic test_basic();
    int cyc;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    n_cmp++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_after_accept: got busy=%b done=%b, want 1 0", busy8, done8);
    end
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 12) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, want 8", cyc);
    end
    n_cmp++;
    if ({cout8, sum8} !== 9'h100) begin
      n_fail++;
      $display("FAIL basic_result: got cout=%b sum=%h, want cout=1 sum=00", cout8, sum8);
    end
    step();
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b one cycle later, want 0 0", done8, busy8);
    end
  endtask

  task automatic test_width1();
    int cyc;
    logic [1:0] r, e;
    for (int i = 0; i < 8; i++) begin
      e = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      run1(i[2], i[1], i[0], cyc, r);
      n_cmp++;
      if (cyc !== 1 || r !== e) begin
        n_fail++;
        $display("FAIL width1_%0d: got cyc=%0d {cout,sum}=%b, want cyc=1 %b", i, cyc, r, e);
      end
      step();
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8 === 1'b1) begin
        n_done++;
        n_cmp++;
        if ({cout8, sum8} !== 9'h100) begin
          n_fail++;
          $display("FAIL ignore_result: got cout=%b sum=%h, want cout=1 sum=00", cout8, sum8);
        end
      end
      step();
    end
    n_cmp++;
    if (n_done !== 1 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_single_done: got %0d done pulses busy=%b, want 1 and 0", n_done, busy8);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int t = 0;
    int t_first = 0;
    int t_second = 0;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'h80; b8 = 8'h80;
    while (n_done < 2 && t < 40) begin
      step();
      t++;
      if (done8 === 1'b1) begin
        n_done++;
        if (n_done == 1) begin
          t_first = t;
          n_cmp++;
          if ({cout8, sum8} !== 9'h030) begin
            n_fail++;
            $display("FAIL b2b_first: got cout=%b sum=%h, want cout=0 sum=30", cout8, sum8);
          end
        end else begin
          t_second = t;
          start8 = 1'b0;
          n_cmp++;
          if ({cout8, sum8} !== 9'h100) begin
            n_fail++;
            $display("FAIL b2b_second: got cout=%b sum=%h, want cout=1 sum=00", cout8, sum8);
          end
        end
      end else if (n_done == 1 && sum8 !== 8'h30) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b2b_hold: got sum=%h between ops, want 30", sum8);
      end
    end
    start8 = 1'b0;
    n_cmp++;
    if (n_done !== 2 || t_first !== 8 || t_second - t_first > 10 || t_second - t_first < 9) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d dones at %0d and %0d, want 2 at 8 and 17..18", n_done, t_first, t_second);
    end
    step();
    step();
  endtask

  task automatic test_mid_reset();
    int cyc;
    int n_done = 0;
    logic [7:0] s;
    logic co;
    run8(8'h12, 8'h34, 1'b0, cyc, s, co);
    n_cmp++;
    if ({co, s} !== 9'h046) begin
      n_fail++;
      $display("FAIL midrst_pre: got cout=%b sum=%h, want cout=0 sum=46", co, s);
    end
    step();
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    rst = 1'b1; start8 = 1'b1;
    step();
    rst = 1'b0; start8 = 1'b0;
    n_cmp++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_state: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got %0d busy/done cycles after reset, want 0", n_done);
    end
    run8(8'h03, 8'h04, 1'b1, cyc, s, co);
    n_cmp++;
    if (cyc !== 8 || {co, s} !== 9'h008) begin
      n_fail++;
      $display("FAIL midrst_fresh: got cyc=%0d cout=%b sum=%h, want 8 0 08", cyc, co, s);
    end
    step();
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] s, ra, rb;
    logic co, rc;
    logic [8:0] e;
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      e = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, cyc, s, co);
      n_cmp++;
      if (cyc !== 8 || {co, s} !== e) begin
        n_fail++;
        $display("FAIL random_%0d: %h+%h+%b got cyc=%0d %h, want 8 %h", i, ra, rb, rc, cyc, {co, s}, e);
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width1();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
